// File: rtl/aec_expr_tx.sv
// Token loader / ASCII streamer for the calculator expression port; captures the calculator's reply.
// Optional WAIT_RES watchdog is compiled in with `define AEC_EXPR_TX_TIMEOUT_EN.
module aec_expr_tx #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tok_valid,
  input  logic [4:0] tok_data,
  output logic       tok_ready,
  output logic [7:0] ascii_out,
  output logic       ready,
  input  logic       result_valid,
  input  logic [6:0] result_in,
  output logic       done,
  output logic [6:0] res_out,
  output logic       err,
  output logic       busy
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [CW-1:0] ptr;
  logic          primed;
  logic [4:0]    tok_buf [DEPTH];

  logic hs;
  logic tok_is_sym;
  logic tok_is_eq;
  logic room;
  logic store;

  assign hs         = tok_valid & tok_ready & (state == S_LOAD);
  assign tok_is_sym = tok_data < 5'd21;
  assign tok_is_eq  = tok_data == 5'd21;
  assign room       = count < CW'(DEPTH);
  assign store      = hs & tok_is_sym & room;

  function automatic logic [7:0] enc(input logic [4:0] t);
    logic [7:0] c;
    c = 8'h00;
    if (t < 5'd10)
      c = 8'h30 + {3'b000, t};
    else if (t < 5'd16)
      c = 8'h61 + {3'b000, t} - 8'd10;
    else begin
      case (t)
        5'd16:   c = 8'h28;
        5'd17:   c = 8'h29;
        5'd18:   c = 8'h2A;
        5'd19:   c = 8'h2B;
        5'd20:   c = 8'h2D;
        default: c = 8'h00;
      endcase
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst && store)
      tok_buf[count[IW-1:0]] <= tok_data;
  end

`ifdef AEC_EXPR_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout;

  // Held at zero outside WAIT_RES, so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (!rst || state != S_WAIT)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == S_WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_LOAD;
      count     <= '0;
      ptr       <= '0;
      primed    <= 1'b0;
      tok_ready <= 1'b0;
      ascii_out <= 8'h00;
      ready     <= 1'b0;
      done      <= 1'b0;
      res_out   <= 7'h00;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_LOAD: begin
          tok_ready <= 1'b1;
          if (hs) begin
            if (tok_is_eq) begin
              if (count == '0)
                err <= 1'b1;
              else begin
                state     <= S_SEND;
                tok_ready <= 1'b0;
                busy      <= 1'b1;
                primed    <= 1'b0;
              end
            end else if (!tok_is_sym || !room)
              err <= 1'b1;
            else begin
              count <= count + 1'b1;
              err   <= 1'b0;
            end
          end
        end
        S_SEND: begin
          // One idle cycle after entry, then count characters and the '=' back to back.
          if (!primed) begin
            primed <= 1'b1;
            ptr    <= '0;
          end else if (ptr < count) begin
            ascii_out <= enc(tok_buf[ptr[IW-1:0]]);
            ready     <= 1'b1;
            ptr       <= ptr + 1'b1;
          end else if (ptr == count) begin
            ascii_out <= 8'h3D;
            ready     <= 1'b1;
            ptr       <= ptr + 1'b1;
          end else begin
            ascii_out <= 8'h00;
            ready     <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (result_valid) begin
            res_out <= result_in;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end
`ifdef AEC_EXPR_TX_TIMEOUT_EN
          else if (timeout) begin
            res_out <= 7'h7F;
            err     <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end
`endif
        end
        default: begin
          count     <= '0;
          tok_ready <= 1'b1;
          state     <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aec_expr_tx.sv
// Bench for aec_expr_tx: directed scenarios plus random expressions against a token-list reference model.
module tb_aec_expr_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tok_valid;
  logic [4:0] tok_data;
  logic       tok_ready;
  logic [7:0] ascii_out;
  logic       ready;
  logic       result_valid;
  logic [6:0] result_in;
  logic       done;
  logic [6:0] res_out;
  logic       err;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [4:0] tq[$];
  bit         err_m;
  logic [6:0] res_m;

  aec_expr_tx #(.DEPTH(16), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_data(tok_data), .tok_ready(tok_ready),
    .ascii_out(ascii_out), .ready(ready),
    .result_valid(result_valid), .result_in(result_in),
    .done(done), .res_out(res_out), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_char(input int t);
    string ops;
    ops = "()*+-";
    if (t < 10) return 8'(48 + t);
    if (t < 16) return 8'(97 + t - 10);
    return ops[t - 16];
  endfunction

  task automatic send_tok(input logic [4:0] t);
    tok_valid = 1'b1;
    tok_data  = t;
    for (int w = 0; w < 20 && !tok_ready; w++) tick();
    if (!tok_ready) check("tok_ready_wait", tok_ready, 1);
    else tick();
    tok_valid = 1'b0;
  endtask

  // Loads tq plus the end token, follows the model and checks the emitted character stream.
  task automatic run_expr(input bit inject, output bit streamed);
    int         stored[$];
    logic [7:0] exp_q[$];
    int         i;
    bit         saw;
    streamed = 1'b0;
    foreach (tq[k]) begin
      send_tok(tq[k]);
      if (tq[k] >= 22 || stored.size() >= 16) err_m = 1'b1;
      else begin
        stored.push_back(int'(tq[k]));
        err_m = 1'b0;
      end
    end
    send_tok(5'd21);
    if (stored.size() == 0) begin
      err_m = 1'b1;
      saw = 1'b0;
      for (int c = 0; c < 5; c++) begin
        if (ready || busy) saw = 1'b1;
        tick();
      end
      check("empty_no_stream", saw, 0);
      check("empty_err", err, err_m);
      check("empty_tok_ready", tok_ready, 1);
      return;
    end
    foreach (stored[k]) exp_q.push_back(ref_char(stored[k]));
    exp_q.push_back(8'h3D);
    tick();
    check("lat_e1_ready", ready, 0);
    check("busy_send", busy, 1);
    check("tok_ready_send", tok_ready, 0);
    tick();
    i = 0;
    saw = 1'b0;
    while (ready && i < 40) begin
      if (i < exp_q.size()) check($sformatf("char%0d", i), ascii_out, exp_q[i]);
      i++;
      result_valid = inject && (i == 2);
      result_in = 7'h55;
      if (done) saw = 1'b1;
      tick();
    end
    result_valid = 1'b0;
    check("stream_len", i, exp_q.size());
    check("ascii_idle", ascii_out, 0);
    check("no_done_in_send", saw, 0);
    check("err_after_stream", err, err_m);
    streamed = 1'b1;
  endtask

  task automatic give_result(input logic [6:0] r, input int dly);
    for (int d = 0; d < dly; d++) tick();
    check("busy_wait", busy, 1);
    check("no_done_before_result", done, 0);
    result_valid = 1'b1;
    result_in    = r;
    tick();
    result_valid = 1'b0;
    check("done_pulse", done, 1);
    check("res_out", res_out, r);
    check("busy_after", busy, 0);
    check("err_at_done", err, err_m);
    res_m = r;
    tick();
    check("done_single", done, 0);
    check("tok_ready_after_done", tok_ready, 1);
  endtask

  initial begin
    bit st;
    rst = 1'b0; tok_valid = 1'b0; tok_data = '0;
    result_valid = 1'b0; result_in = '0;
    err_m = 1'b0; res_m = '0;
    tick(); tick();
    check("rst_tok_ready", tok_ready, 0);
    check("rst_ascii", ascii_out, 0);
    check("rst_ready", ready, 0);
    check("rst_done", done, 0);
    check("rst_res", res_out, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    tick();
    check("tok_ready_after_rst", tok_ready, 1);

    tq = '{5'd3, 5'd19, 5'd4};
    run_expr(1'b0, st);
    if (st) give_result(7'd7, 0);

    tq = '{5'd16, 5'd10, 5'd18, 5'd2, 5'd17, 5'd20, 5'd15};
    run_expr(1'b1, st);
    if (st) give_result(7'd100, 2);

    tq = {};
    repeat (17) tq.push_back(5'd1);
    tq.push_back(5'd25);
    run_expr(1'b0, st);
    check("overflow_err", err, 1);
    if (st) give_result(7'd16, 1);

    tq = {};
    run_expr(1'b0, st);

    result_valid = 1'b1; result_in = 7'h2A;
    tick();
    result_valid = 1'b0;
    check("rv_load_no_done", done, 0);
    tick();
    check("rv_load_res_hold", res_out, res_m);

    // Abort mid-stream with a synchronous reset on the third character.
    tq = '{5'd1, 5'd2, 5'd3, 5'd4};
    foreach (tq[k]) send_tok(tq[k]);
    send_tok(5'd21);
    tick(); tick(); tick(); tick();
    check("third_char", ascii_out, 8'h33);
    rst = 1'b0;
    tick();
    check("abort_ready", ready, 0);
    check("abort_ascii", ascii_out, 0);
    check("abort_tok_ready", tok_ready, 0);
    check("abort_busy", busy, 0);
    rst = 1'b1;
    err_m = 1'b0; res_m = '0;
    tick();
    check("abort_tok_ready_back", tok_ready, 1);
    check("abort_res", res_out, res_m);
    tq = '{5'd5};
    run_expr(1'b0, st);
    if (st) give_result(7'd9, 0);

    for (int n = 0; n < 8; n++) begin
      int len;
      len = $urandom_range(0, 18);
      tq = {};
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 7) == 0) tq.push_back(5'($urandom_range(22, 31)));
        else tq.push_back(5'($urandom_range(0, 20)));
      end
      run_expr(1'($urandom_range(0, 1)), st);
      if (st) give_result(7'($urandom_range(0, 127)), $urandom_range(0, 3));
    end

`ifdef AEC_EXPR_TX_TIMEOUT_EN
    begin
      int w;
      tq = '{5'd1};
      run_expr(1'b0, st);
      w = 0;
      while (!done && w < 40) begin
        tick();
        w++;
      end
      check("to_done", done, 1);
      check("to_latency", (w >= 9 && w <= 11), 1);
      check("to_res", res_out, 7'h7F);
      check("to_err", err, 1);
      err_m = 1'b1; res_m = 7'h7F;
      tick();
      check("to_tok_ready", tok_ready, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aec_expr_tx.md
Name: aec_expr_tx

Overview:
- Transmit end of the calculator's ASCII expression interface.
- A host loads an expression as compact token codes, ending with an end token.
- The block streams the expression as ASCII characters, one per cycle with `ready` high, terminated by '='.
- It then waits for the calculator's `valid`/`result`, captures the result and reports it to the host.

Parameters:
- DEPTH, 16, max stored tokens excluding '=' (matches calculator's 16-entry buffer)
- TIMEOUT_CYCLES, 255, WAIT_RES watchdog limit (used only with AEC_EXPR_TX_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset (rst=0 resets on clk edge)
- tok_valid  in  1  host token valid
- tok_data  in  5  token: 0-15 operand, 16 '(', 17 ')', 18 '*', 19 '+', 20 '-', 21 '=' (end), 22-31 illegal
- tok_ready  out  1  block accepts token
- ascii_out  out  8  ASCII character to calculator
- ready  out  1  ascii_out holds a valid character this cycle
- result_valid  in  1  calculator result strobe
- result_in  in  7  calculator result
- done  out  1  one-cycle pulse, res_out valid
- res_out  out  7  captured result
- err  out  1  sticky error flag, cleared by reset or by the next accepted token in LOAD
- busy  out  1  high in SEND and WAIT_RES

Behaviour:
- Reset values: tok_ready=0, ascii_out=8'h00, ready=0, done=0, res_out=0, err=0, busy=0, count=0, state=LOAD. Reset in any state aborts immediately; no partial stream resumes.
- States: LOAD, SEND, WAIT_RES, DONE.
- Outputs are registered. tok_ready=1 only in LOAD, one cycle after reset release.
- LOAD, handshake tok_valid&tok_ready on an edge:
  - Operand/operator with count<DEPTH: store at buf[count], count+1.
  - Operand/operator with count==DEPTH: token dropped, err=1.
  - Illegal code 22-31: token dropped, err=1.
  - '=' with count==0: token dropped, err=1, stay LOAD.
  - '=' with count>0: go to SEND, tok_ready=0 from the next cycle. '=' is not stored.
- SEND:
  - ready is high for exactly count+1 consecutive cycles, starting the cycle after SEND is entered.
  - Characters are buf[0..count-1] in order, then 8'h3D.
  - Encoding: 0-9 -> 8'h30+v; 10-15 -> lowercase 8'h61+(v-10); '(' 28, ')' 29, '*' 2A, '+' 2B, '-' 2D.
  - After the '=' cycle: ready=0, ascii_out=8'h00, go to WAIT_RES. No gaps or stalls are permitted mid-stream.
- WAIT_RES:
  - On result_valid=1: res_out<=result_in, go to DONE.
  - result_valid in LOAD or SEND is ignored.
- DONE: done=1 for one cycle, count cleared, go to LOAD (tok_ready=1 the following cycle). res_out holds until the next capture.
- tok_valid outside LOAD is ignored. The host must hold tok_valid/tok_data until the handshake.
- Latency: '=' handshake edge E; first character visible after edge E+2; '=' character after edge E+2+count.

Optional Feature:
- Macro: AEC_EXPR_TX_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RES.
  - If TIMEOUT_CYCLES cycles pass without result_valid: err=1, res_out=7'h7F, done pulses, return to LOAD.
  - Counter clears on state entry.
- Undefined: WAIT_RES waits indefinitely; no counter logic exists.

Test Plan:
- Basic stream: tokens 3,19,4,21 -> 4 consecutive ready cycles with ascii_out 33,2B,34,3D; result_valid with result_in=7 -> done one cycle, res_out=7, err=0.
- Hex and parentheses: tokens 16,10,18,2,17,20,15,21 -> 28,61,2A,32,29,2D,66,3D contiguous; then tok_ready=1 after done.
- Overflow and illegal: 17 operand tokens of value 1, then code 25, then 21 -> err=1; exactly 16 '1' chars (31) then 3D.
- Empty expression and ignored inputs:
  - 21 with count==0 -> err=1, ready never asserts, stays LOAD.
  - result_valid pulsed during LOAD/SEND -> no done.
- Reset mid-SEND: rst=0 on the 3rd character cycle -> next cycle ready=0, ascii_out=00, tok_ready=0, then 1 one cycle after rst=1; a fresh 5,21 streams 35,3D.
- Timeout (macro defined, TIMEOUT_CYCLES=10): stream 1,21, withhold result_valid -> after 10 cycles done pulses, res_out=7F, err=1.
